// File: rtl/dl_shift_arb.sv
// Round-robin arbiter sharing one barrel shifter among NUM_REQ requesters,
// each with a private registered response slot. Left shift: DL_SHIFT_ARB_LSHIFT_EN.
module dl_shift_arb #(
  parameter  int NUM_BITS = 32,
  parameter  int NUM_REQ  = 2,
  localparam int SHAMT_W  = $clog2(NUM_BITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_sh_type,
  input  logic [NUM_REQ-1:0]          req_sh_dir,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0]  req_shamt,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [NUM_REQ*NUM_BITS-1:0] rsp_data
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*NUM_BITS-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] elig, grant;
  logic [PTR_W-1:0]   gidx, pick;
  logic [PTR_W:0]     scan;
  logic               found;

  function automatic logic [NUM_BITS-1:0] shift_right(input logic [NUM_BITS-1:0] v,
                                                      input logic [SHAMT_W-1:0] sh,
                                                      input logic fill);
    logic signed [NUM_BITS:0] ext;
    ext = $signed({fill, v});
    ext = ext >>> sh;
    return ext[NUM_BITS-1:0];
  endfunction

  function automatic logic [NUM_BITS-1:0] bitrev(input logic [NUM_BITS-1:0] v);
    logic [NUM_BITS-1:0] r;
    for (int b = 0; b < NUM_BITS; b++) r[b] = v[NUM_BITS-1-b];
    return r;
  endfunction

  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  // Scan from rr_ptr with wrap; scan never exceeds 2*NUM_REQ-2 so one subtract suffices.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    scan  = '0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan >= NREQ) scan = scan - NREQ;
      pick = scan[PTR_W-1:0];
      if (!found && elig[pick]) begin
        found       = 1'b1;
        grant[pick] = 1'b1;
        gidx        = pick;
      end
    end
  end

  assign req_ready = rst ? '0 : grant;

  logic [NUM_BITS-1:0] op_data, sh_in, sh_out, sh_res;
  logic [SHAMT_W-1:0]  op_shamt;
  logic                op_type, sh_fill;

  assign op_data  = req_data[gidx*NUM_BITS +: NUM_BITS];
  assign op_shamt = req_shamt[gidx*SHAMT_W +: SHAMT_W];
  assign op_type  = req_sh_type[gidx];

`ifdef DL_SHIFT_ARB_LSHIFT_EN
  logic op_dir;
  assign op_dir  = req_sh_dir[gidx];
  assign sh_in   = op_dir ? bitrev(op_data) : op_data;
  assign sh_fill = op_type & ~op_dir & sh_in[NUM_BITS-1];
  assign sh_out  = shift_right(sh_in, op_shamt, sh_fill);
  assign sh_res  = op_dir ? bitrev(sh_out) : sh_out;
`else
  logic unused_dir;
  assign unused_dir = ^req_sh_dir;
  assign sh_in   = op_data;
  assign sh_fill = op_type & sh_in[NUM_BITS-1];
  assign sh_out  = shift_right(sh_in, op_shamt, sh_fill);
  assign sh_res  = sh_out;
`endif

  // A grant in the same cycle as a drain keeps the slot full with no bubble.
  always_comb begin
    rsp_valid_d = (rsp_valid_q & ~rsp_ready) | grant;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) rsp_data_d[i*NUM_BITS +: NUM_BITS] = sh_res;
    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dl_shift_arb.sv
// Self-checking bench for dl_shift_arb: directed scenarios plus randomized
// traffic against a behavioural round-robin / shift reference model.
module tb_dl_shift_arb;
  localparam int NB = 32;
  localparam int NR = 2;
  localparam int SW = $clog2(NB);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0, req_ready, req_sh_type = '0, req_sh_dir = '0;
  logic [NR*NB-1:0]  req_data = '0;
  logic [NR*SW-1:0]  req_shamt = '0;
  logic [NR-1:0]     rsp_valid, rsp_ready = '0;
  logic [NR*NB-1:0]  rsp_data;

  dl_shift_arb #(.NUM_BITS(NB), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sh_type(req_sh_type), .req_sh_dir(req_sh_dir),
    .req_data(req_data), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int rr = 0;
  bit mv[NR];
  logic [NB-1:0] md[NR];
  int last_g = -1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] mshift(input logic [NB-1:0] d, input int s,
                                           input bit t, input bit dir);
    logic [NB-1:0] ones, r;
    ones = '1;
`ifdef DL_SHIFT_ARB_LSHIFT_EN
    if (dir) return d << s;
`endif
    r = d >> s;
    if (t && d[NB-1]) r = r | ~(ones >> s);
    return r;
  endfunction

  function automatic int mgrant();
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (rr + k) % NR;
      if (req_valid[i] && (!mv[i] || rsp_ready[i])) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    rr = 0;
    for (int i = 0; i < NR; i++) begin mv[i] = 0; md[i] = '0; end
  endtask

  task automatic check_rsp(input string tag);
    for (int i = 0; i < NR; i++) begin
      check_eq($sformatf("%s rsp_valid%0d", tag, i), 64'(rsp_valid[i]), 64'(mv[i]));
      check_eq($sformatf("%s rsp_data%0d", tag, i), 64'(rsp_data[i*NB +: NB]), 64'(md[i]));
    end
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    int g;
    logic [NR-1:0] e;
    #1;
    g = mgrant();
    e = '0;
    if (g >= 0) e[g] = 1'b1;
    check_eq({tag, " req_ready"}, 64'(req_ready), 64'(e));
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (mv[i] && rsp_ready[i]) mv[i] = 0;
    if (g >= 0) begin
      mv[g] = 1;
      md[g] = mshift(req_data[g*NB +: NB], int'(req_shamt[g*SW +: SW]),
                     req_sh_type[g], req_sh_dir[g]);
      rr = (g + 1) % NR;
    end
    last_g = g;
    #1;
    check_rsp(tag);
  endtask

  task automatic set_req(input int i, input bit v, input logic [NB-1:0] d,
                         input int s, input bit t, input bit dir);
    req_valid[i] = v;
    req_data[i*NB +: NB] = d;
    req_shamt[i*SW +: SW] = SW'(s);
    req_sh_type[i] = t;
    req_sh_dir[i] = dir;
  endtask

  bit hold[NR];
  logic [NB-1:0] exp_l;

  initial begin
    model_reset();
    req_valid = '1;
    rsp_ready = '1;
    #2;
    check_eq("reset req_ready", 64'(req_ready), 64'd0);
    check_eq("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("reset rsp_data", 64'(rsp_data), 64'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single op, arithmetic then logical right shift
    rsp_ready = '0;
    set_req(0, 1, 32'h8000_0000, 4, 1, 0);
    cycle("sra");
    check_eq("sra result", 64'(rsp_data[NB-1:0]), 64'hF800_0000);
    set_req(0, 1, 32'h8000_0000, 4, 0, 0);
    rsp_ready = 2'b01;
    cycle("srl");
    check_eq("srl result", 64'(rsp_data[NB-1:0]), 64'h0800_0000);
    req_valid = '0;
    rsp_ready = '1;
    cycle("drain");

    // Contention: alternate grants
    set_req(0, 1, 32'h1234_5678, 3, 0, 0);
    set_req(1, 1, 32'h9ABC_DEF0, 7, 1, 0);
    for (int c = 0; c < 6; c++) begin
      req_data[0 +: NB] = $urandom;
      req_data[NB +: NB] = $urandom;
      cycle("contend");
    end

    // Backpressure on slot 0, then release
    rsp_ready = 2'b10;
    for (int c = 0; c < 4; c++) cycle("bp");
    check_eq("bp slot0 held", 64'(rsp_valid[0]), 64'd1);
    rsp_ready = 2'b11;
    cycle("bp release");
    check_eq("bp release grant0", 64'(last_g), 64'd0);

    // Drain plus grant on req0 alone
    req_valid = 2'b01;
    for (int c = 0; c < 4; c++) begin
      req_data[0 +: NB] = $urandom;
      cycle("drain+grant");
    end

    // Left shift
    set_req(0, 1, 32'h0000_0001, 31, 1, 1);
    cycle("lsl");
`ifdef DL_SHIFT_ARB_LSHIFT_EN
    exp_l = 32'h8000_0000;
`else
    exp_l = 32'h0000_0000;
`endif
    check_eq("lsl result", 64'(rsp_data[NB-1:0]), 64'(exp_l));
    req_valid = '0;
    cycle("idle");

    // Randomized traffic with operand hold until granted
    for (int i = 0; i < NR; i++) hold[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!hold[i])
          set_req(i, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, NB-1),
                  $urandom_range(0, 1), $urandom_range(0, 1));
      rsp_ready = NR'($urandom);
      cycle("rand");
      for (int i = 0; i < NR; i++) hold[i] = req_valid[i] && (last_g != i);
    end

    // Reset mid-operation with rsp_valid = 10
    req_valid = '0;
    rsp_ready = '1;
    cycle("pre-rst drain");
    rsp_ready = '0;
    set_req(1, 1, 32'hA5A5_0F0F, 5, 1, 0);
    cycle("pre-rst load");
    check_eq("pre-rst rsp_valid", 64'(rsp_valid), 64'b10);
    req_valid = '1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("midrst rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("midrst rsp_data", 64'(rsp_data), 64'd0);
    check_eq("midrst req_ready", 64'(req_ready), 64'd0);
    #2 rst = 1'b0;
    rsp_ready = '1;
    cycle("post-rst");
    check_eq("post-rst grant0", 64'(last_g), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
